// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-facing signal bundle for uart_tx_fifo.
// The slave side is the FIFO; the master side is the producer plus transmitter.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                ovf_clr;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                tx_busy;

    modport master (
        output wr_data, wr_en, ovf_clr, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_start
    );

    modport slave (
        input  wr_data, wr_en, ovf_clr, tx_busy,
        output full, empty, count, overflow, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a held TX_START / TX_BUSY handshake.
// The offered byte stays in the array until the transmitter acknowledges it.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        START     = 2'b01,
        WAIT_DONE = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_r;
    logic [DEPTH_LOG2-1:0] rp_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  overflow_r;
    logic                  tx_start_r;
    logic [7:0]            tx_data_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_ok_s;
    logic                  load_s;
    logic                  pop_s;

    // Flags come from the pre-edge count, so a write while full is refused even on a pop edge.
    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);
    assign wr_ok_s = bus.wr_en & ~full_s;

    assign bus.full     = full_s;
    assign bus.empty    = empty_s;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;
    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Drain FSM next-state: offer a byte, hold until busy is seen, then wait for the line to free up.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && !bus.tx_busy) begin
                    load_s     = 1'b1;
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (bus.tx_busy) begin
                    pop_s      = 1'b1;
                    state_nx_s = WAIT_DONE;
                end else begin
                    state_nx_s = START;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Storage array and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wp_r <= PTR_ZERO;
        end else if (wr_ok_s) begin
            mem_r[wp_r] <= bus.wr_data;
            wp_r        <= wp_r + PTR_ONE;
        end else begin
            wp_r <= wp_r;
        end
    end

    // Read pointer and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_r    <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (pop_s) begin
                rp_r <= rp_r + PTR_ONE;
            end else begin
                rp_r <= rp_r;
            end
            case ({wr_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow; a new overflow wins over a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (bus.wr_en && full_s) begin
            overflow_r <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Transmitter request; TX_DATA keeps its last value after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else if (load_s) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= mem_r[rp_r];
        end else if (pop_s) begin
            tx_start_r <= 1'b0;
        end else begin
            tx_start_r <= tx_start_r;
        end
    end
endmodule
